// File: rtl/decoder_index_encoder.sv
// decoder_index_encoder: turns a multi-hot request vector into a stream of set-bit indices.
// Define DECODER_INDEX_ENCODER_MSB_FIRST_EN to emit indices highest-first instead of lowest-first.
module decoder_index_encoder (
   input  logic       clk,
   input  logic       rst,
   input  logic       en,
   input  logic [7:0] in_vec,
   input  logic       in_valid,
   output logic       in_ready,
   output logic [2:0] out_idx,
   output logic       out_valid,
   input  logic       out_ready,
   output logic       out_last
);
   typedef enum logic {IDLE, EMIT} state_t;
   state_t     state;
   logic [7:0] pending;
   // pending is zero in IDLE, so the index and last flag decode to 0 there
   always_comb begin
      out_idx = '0;
`ifdef DECODER_INDEX_ENCODER_MSB_FIRST_EN
      for (int i = 0; i < 8; i++) if (pending[i]) out_idx = 3'(i);
`else
      for (int i = 7; i >= 0; i--) if (pending[i]) out_idx = 3'(i);
`endif
   end
   assign out_valid = state == EMIT;
   assign in_ready  = en && state == IDLE;
   assign out_last  = out_valid && ((pending & (pending - 8'd1)) == 8'd0);
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state   <= IDLE;
         pending <= '0;
      end else if (en) begin
         if (state == IDLE && in_valid && in_vec != 8'd0) begin
            pending <= in_vec;
            state   <= EMIT;
         end else if (state == EMIT && out_ready) begin
            pending <= pending & ~(8'd1 << out_idx);
            state   <= out_last ? IDLE : EMIT;
         end
      end
   end
endmodule

// File: tb/tb_decoder_index_encoder.sv
// tb_decoder_index_encoder: queue-based reference model with a per-cycle comparator
// plus directed scenarios with literal expectations.
module tb_decoder_index_encoder;
   logic       clk = 0, rst = 0, en = 1, in_valid = 0, out_ready = 0;
   logic [7:0] in_vec = 0;
   logic       in_ready, out_valid, out_last;
   logic [2:0] out_idx;
   int         n_cmp = 0, n_bad = 0;
   int         q[$];
   int         ord[4];

   decoder_index_encoder dut (
      .clk(clk), .rst(rst), .en(en), .in_vec(in_vec), .in_valid(in_valid),
      .in_ready(in_ready), .out_idx(out_idx), .out_valid(out_valid),
      .out_ready(out_ready), .out_last(out_last));

   always #5 clk = ~clk;

   task automatic chk(input string name, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // Model: the outstanding indices of the current vector, in emission order
   always @(posedge clk or posedge rst) begin
      if (rst) q.delete();
      else if (en) begin
         if (q.size() == 0 && in_valid && in_vec != 0) begin
            for (int i = 0; i < 8; i++)
               if (in_vec[i])
`ifdef DECODER_INDEX_ENCODER_MSB_FIRST_EN
                  q.push_front(i);
`else
                  q.push_back(i);
`endif
         end else if (q.size() > 0 && out_ready) void'(q.pop_front());
      end
   end

   always @(negedge clk) begin
      chk("m_out_valid", int'(out_valid), int'(q.size() > 0));
      chk("m_out_idx",   int'(out_idx),   q.size() > 0 ? q[0] : 0);
      chk("m_out_last",  int'(out_last),  int'(q.size() == 1));
      chk("m_in_ready",  int'(in_ready),  q.size() > 0 ? 0 : int'(en));
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic load(input logic [7:0] v);
      in_vec = v;
      in_valid = 1;
      step();
      in_valid = 0;
   endtask

   initial begin
`ifdef DECODER_INDEX_ENCODER_MSB_FIRST_EN
      ord = '{7, 5, 2, 0};
`else
      ord = '{0, 2, 5, 7};
`endif
      #1 rst = 1;
      step();
      step();
      rst = 0;
      #1;
      chk("reset_in_ready", int'(in_ready), 1);
      chk("reset_out_valid", int'(out_valid), 0);
      chk("reset_out_idx", int'(out_idx), 0);

      // ascending/descending stream with out_ready held
      out_ready = 1;
      load(8'hA5);
      for (int k = 0; k < 4; k++) begin
         chk("a5_valid", int'(out_valid), 1);
         chk("a5_idx", int'(out_idx), ord[k]);
         chk("a5_last", int'(out_last), int'(k == 3));
         step();
      end
      chk("a5_done_valid", int'(out_valid), 0);
      chk("a5_done_ready", int'(in_ready), 1);

      // zero vector is dropped
      in_vec = 8'h00;
      in_valid = 1;
      for (int k = 0; k < 2; k++) begin
         step();
         chk("zero_valid", int'(out_valid), 0);
         chk("zero_ready", int'(in_ready), 1);
      end
      in_valid = 0;

      // single bit, stalled downstream
      out_ready = 0;
      load(8'h10);
      for (int k = 0; k < 3; k++) begin
         chk("stall_idx", int'(out_idx), 4);
         chk("stall_last", int'(out_last), 1);
         chk("stall_valid", int'(out_valid), 1);
         step();
      end
      out_ready = 1;
      step();
      chk("stall_done_valid", int'(out_valid), 0);
      chk("stall_done_ready", int'(in_ready), 1);

      // asynchronous reset mid-vector
      load(8'hFF);
      step();
      step();
      step();
      chk("ff_before_rst_valid", int'(out_valid), 1);
      #2 rst = 1;
      #1;
      chk("rst_async_valid", int'(out_valid), 0);
      chk("rst_async_idx", int'(out_idx), 0);
      chk("rst_async_last", int'(out_last), 0);
      step();
      rst = 0;
      step();
      chk("after_rst_valid", int'(out_valid), 0);
      chk("after_rst_ready", int'(in_ready), 1);

      // enable low freezes emission
      load(8'hA5);
      step();
      en = 0;
      for (int k = 0; k < 3; k++) begin
         step();
         chk("en0_idx", int'(out_idx), ord[1]);
         chk("en0_valid", int'(out_valid), 1);
         chk("en0_ready", int'(in_ready), 0);
      end
      en = 1;
      for (int k = 1; k < 4; k++) begin
         chk("resume_idx", int'(out_idx), ord[k]);
         chk("resume_last", int'(out_last), int'(k == 3));
         step();
      end
      chk("resume_done", int'(out_valid), 0);

      // enable low in IDLE blocks acceptance
      en = 0;
      in_vec = 8'h01;
      in_valid = 1;
      step();
      step();
      chk("en0_idle_valid", int'(out_valid), 0);
      in_valid = 0;
      en = 1;

      // mixed vectors with toggling out_ready, checked by the model
      foreach (ord[j]) begin
         logic [7:0] vecs[4];
         int t;
         vecs = '{8'h80, 8'h01, 8'h3C, 8'h81};
         load(vecs[j]);
         t = 0;
         while (out_valid && t < 40) begin
            out_ready = t[0];
            step();
            t++;
         end
         chk("mix_timeout", int'(t < 40), 1);
         out_ready = 1;
         step();
      end

      step();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
